// File: rtl/argmax_unit.sv
// argmax_unit: sequential argmax over one frame of signed scores.
// Scores stream in one per cycle over a valid/ready handshake. The block
// reports the zero-based index and the value of the largest score. On a tie,
// the earliest index is kept.
// Optional feature macro: ARGMAX_LEN_CHECK_EN. When it is defined, out_err
// flags frames whose beat count differs from N_CLASSES. A saturated count
// also counts as a mismatch. When it is undefined, out_err is tied low.
module argmax_unit #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 33,
    parameter int IDX_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic signed [DATA_W-1:0] out_max,
    output logic                     out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] CNT_MAX  = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] CNT_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] CNT_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t                    state_r;
    state_t                    state_next_s;
    logic signed [DATA_W-1:0]  best_r;
    logic signed [DATA_W-1:0]  best_next_s;
    logic [IDX_W-1:0]          best_idx_r;
    logic [IDX_W-1:0]          best_idx_next_s;
    logic [IDX_W-1:0]          count_r;
    logic [IDX_W-1:0]          count_next_s;
    logic                      sat_next_s;
    logic                      in_ready_r;
    logic                      out_valid_r;
    logic [IDX_W-1:0]          out_index_r;
    logic signed [DATA_W-1:0]  out_max_r;
    logic                      beat_s;
    logic                      result_s;
    logic                      hold_entry_s;

    // in_ready comes from a register, so it never sees out_ready combinationally.
    assign beat_s       = in_valid && in_ready_r;
    assign result_s     = out_valid_r && out_ready;
    assign hold_entry_s = (state_next_s == HOLD) && (state_r != HOLD);

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_index = out_index_r;
    assign out_max   = out_max_r;

    // Next-state and accumulator update; the updated best/idx feed the output latch directly.
    always_comb begin
        state_next_s    = state_r;
        best_next_s     = best_r;
        best_idx_next_s = best_idx_r;
        count_next_s    = count_r;
        sat_next_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    best_next_s     = in_data;
                    best_idx_next_s = CNT_ZERO;
                    count_next_s    = CNT_ONE;
                    state_next_s    = in_last ? HOLD : ACCUM;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCUM: begin
                if (beat_s) begin
                    // Strictly greater only, so ties keep the earlier index.
                    if (in_data > best_r) begin
                        best_next_s     = in_data;
                        best_idx_next_s = count_r;
                    end else begin
                        best_next_s     = best_r;
                        best_idx_next_s = best_idx_r;
                    end
                    if (count_r == CNT_MAX) begin
                        count_next_s = CNT_MAX;
                        sat_next_s   = 1'b1;
                    end else begin
                        count_next_s = count_r + CNT_ONE;
                    end
                    state_next_s = in_last ? HOLD : ACCUM;
                end else begin
                    state_next_s = ACCUM;
                end
            end
            HOLD: begin
                if (result_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and per-frame accumulators; reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            best_r     <= '0;
            best_idx_r <= CNT_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            state_r    <= state_next_s;
            best_r     <= best_next_s;
            best_idx_r <= best_idx_next_s;
            count_r    <= count_next_s;
        end
    end

    // Registered handshake flags and the result, which is captured only on HOLD entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_index_r <= CNT_ZERO;
            out_max_r   <= '0;
        end else begin
            in_ready_r  <= (state_next_s != HOLD);
            out_valid_r <= (state_next_s == HOLD);
            if (hold_entry_s) begin
                out_index_r <= best_idx_next_s;
                out_max_r   <= best_next_s;
            end else begin
                out_index_r <= out_index_r;
                out_max_r   <= out_max_r;
            end
        end
    end

`ifdef ARGMAX_LEN_CHECK_EN
    localparam logic [IDX_W-1:0] N_CLASSES_CNT = IDX_W'(N_CLASSES);

    logic sat_r;
    logic sat_frame_s;
    logic err_next_s;
    logic out_err_r;

    // A frame with any saturated increment is treated as a length mismatch.
    assign sat_frame_s = (state_r == IDLE) ? 1'b0 : (sat_r || sat_next_s);
    assign err_next_s  = sat_frame_s || (count_next_s != N_CLASSES_CNT);
    assign out_err     = out_err_r;

    // Sticky saturation flag, cleared by the first beat of each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_r <= 1'b0;
        end else if (beat_s) begin
            sat_r <= sat_frame_s;
        end else begin
            sat_r <= sat_r;
        end
    end

    // Length error is latched with the result and held through HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_err_r <= 1'b0;
        end else if (hold_entry_s) begin
            out_err_r <= err_next_s;
        end else begin
            out_err_r <= out_err_r;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_argmax_unit.sv
// Directed testbench for argmax_unit. Expected results are hand-computed.
// When ARGMAX_LEN_CHECK_EN is defined, the expected out_err values follow it.
module tb_argmax_unit;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [32:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_index;
    logic signed [32:0] out_max;
    logic               out_err;

    int checks = 0;
    int errors = 0;

`ifdef ARGMAX_LEN_CHECK_EN
    localparam logic LEN_ERR = 1'b1;
`else
    localparam logic LEN_ERR = 1'b0;
`endif

    argmax_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_max   (out_max),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one beat at a negedge and wait (bounded) until the beat is accepted.
    task automatic send_beat(input int d, input logic last);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 33'(d);
        in_last  = last;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_accept: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
    endtask

    // Check the result in the cycle after the last beat (this also checks latency).
    task automatic check_result(input string name, input logic [3:0] ei,
                                input int em, input logic ee);
        logic signed [32:0] em33;
        em33 = 33'(em);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid: got %b required 1", name, out_valid);
        end
        checks++;
        if (out_index !== ei) begin
            errors++;
            $display("FAIL %s out_index: got %0d required %0d", name, out_index, ei);
        end
        checks++;
        if (out_max !== em33) begin
            errors++;
            $display("FAIL %s out_max: got %0d required %0d", name, out_max, em33);
        end
        checks++;
        if (out_err !== ee) begin
            errors++;
            $display("FAIL %s out_err: got %b required %b", name, out_err, ee);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s in_ready_hold: got %b required 0", name, in_ready);
        end
    endtask

    // Accept the result, then expect IDLE with in_ready high one cycle later.
    task automatic consume(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s consume out_valid: got %b required 0", name, out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s consume in_ready: got %b required 1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 33'sd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_err} !== 3'b000 || out_index !== 4'd0 || out_max !== 33'sd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b err=%b idx=%0d max=%0d required all 0",
                     in_ready, out_valid, out_err, out_index, out_max);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic_frame();
        int vals [10] = '{5, 12, 3, 40, 7, 0, 9, 40, 1, 2};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send_beat(vals[i], (i == 9));
        check_result("basic_tie", 4'd3, 40, 1'b0);
        consume("basic_tie");
    endtask

    task automatic test_single_beat();
        out_ready = 1'b0;
        send_beat(17, 1'b1);
        check_result("single", 4'd0, 17, LEN_ERR);
        consume("single");
    endtask

    task automatic test_negative_and_zero();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) send_beat(-i, (i == 10));
        check_result("negatives", 4'd0, -1, 1'b0);
        consume("negatives");
        for (int i = 0; i < 10; i++) send_beat(0, (i == 9));
        check_result("zeros", 4'd0, 0, 1'b0);
        consume("zeros");
        send_beat(-5, 1'b0);
        send_beat(3, 1'b0);
        send_beat(-100, 1'b1);
        check_result("mixed_sign", 4'd1, 3, LEN_ERR);
        consume("mixed_sign");
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        send_beat(3, 1'b0);
        send_beat(7, 1'b0);
        send_beat(5, 1'b1);
        check_result("bp", 4'd1, 7, LEN_ERR);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = 33'sd1000;
            in_last  = 1'b1;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_index !== 4'd1 || out_max !== 33'sd7) begin
                errors++;
                $display("FAIL bp_stall cycle %0d: vld=%b rdy=%b idx=%0d max=%0d required 1 0 1 7",
                         c, out_valid, in_ready, out_index, out_max);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume("bp");
        send_beat(2, 1'b0);
        send_beat(9, 1'b1);
        check_result("bp_next", 4'd1, 9, LEN_ERR);
        consume("bp_next");
    endtask

    task automatic test_gaps_and_reset();
        int gvals [4] = '{1, 2, 99, 4};
        int gaps  [4] = '{2, 1, 3, 0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_beat(gvals[i], (i == 3));
            if (gaps[i] > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = 33'sd500;
                repeat (gaps[i]) @(posedge clk);
            end
        end
        check_result("gaps", 4'd2, 99, LEN_ERR);
        consume("gaps");
        send_beat(100, 1'b0);
        send_beat(200, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_err} !== 3'b000 || out_index !== 4'd0 || out_max !== 33'sd0) begin
            errors++;
            $display("FAIL midframe_reset: rdy=%b vld=%b err=%b idx=%0d max=%0d required all 0",
                     in_ready, out_valid, out_err, out_index, out_max);
        end
        @(negedge clk);
        rst = 1'b0;
        send_beat(8, 1'b0);
        send_beat(9, 1'b1);
        check_result("after_reset", 4'd1, 9, LEN_ERR);
        consume("after_reset");
    endtask

    task automatic test_length_check();
        out_ready = 1'b1;
        for (int i = 1; i <= 7; i++) send_beat(i, (i == 7));
        check_result("len7", 4'd6, 7, LEN_ERR);
        consume("len7");
        for (int i = 0; i < 10; i++) send_beat(10 - i, (i == 9));
        check_result("len10", 4'd0, 10, 1'b0);
        consume("len10");
        for (int i = 0; i < 17; i++) send_beat(i, (i == 16));
        check_result("len17_sat", 4'd15, 16, LEN_ERR);
        consume("len17_sat");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_single_beat();
        test_negative_and_zero();
        test_back_pressure();
        test_gaps_and_reset();
        test_length_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
